// File: rtl/match_controller.sv
// Round/match sequencer: countdown -> fight -> round result -> next round until a player wins the match.
// Define MATCH_TIMEOUT_EN to give FIGHT a time limit; otherwise rounds end only by knockout.
module match_controller #(
  parameter int HEALTH_W      = 3,
  parameter int TIMER_W       = 7,
  parameter int TICK_DIV      = 60,
  parameter int COUNTDOWN_S   = 3,
  parameter int ROUND_TIME_S  = 99,
  parameter int RESULT_HOLD_S = 2,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int MAX_ROUNDS    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [HEALTH_W-1:0] p1_health,
  input  logic [HEALTH_W-1:0] p2_health,
  output logic [2:0]          match_state,
  output logic [TIMER_W-1:0]  round_timer,
  output logic [2:0]          round_num,
  output logic [2:0]          p1_wins,
  output logic [2:0]          p2_wins,
  output logic [1:0]          round_result,
  output logic [1:0]          match_result,
  output logic                freeze,
  output logic                tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COUNTDOWN = 3'd1;
  localparam logic [2:0] S_FIGHT     = 3'd2;
  localparam logic [2:0] S_ROUND_END = 3'd3;
  localparam logic [2:0] S_MATCH_END = 3'd4;

  localparam logic [1:0] R_NONE = 2'b00;
  localparam logic [1:0] R_P1   = 2'b01;
  localparam logic [1:0] R_P2   = 2'b10;
  localparam logic [1:0] R_DRAW = 2'b11;

  localparam logic [TIMER_W-1:0] T_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_CD   = TIMER_W'(COUNTDOWN_S);
  localparam logic [TIMER_W-1:0] T_HOLD = TIMER_W'(RESULT_HOLD_S);
  localparam logic [2:0]         WIN_MAX   = 3'(ROUNDS_TO_WIN);
  localparam logic [2:0]         ROUND_MAX = 3'(MAX_ROUNDS);

`ifdef MATCH_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] T_FIGHT = TIMER_W'(ROUND_TIME_S);
`else
  localparam logic [TIMER_W-1:0] T_FIGHT = '0;
`endif

  if (COUNTDOWN_S < 1 || RESULT_HOLD_S < 1 || ROUNDS_TO_WIN < 1 || ROUND_TIME_S < 1 ||
      ROUND_TIME_S >= 2**TIMER_W || MAX_ROUNDS < 2*ROUNDS_TO_WIN-1 || MAX_ROUNDS > 7) begin : g_bad_params
    $error("match_controller: illegal parameter combination");
  end

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         round_q, round_d;
  logic [2:0]         p1w_q, p1w_d;
  logic [2:0]         p2w_q, p2w_d;
  logic [1:0]         rres_q, rres_d;
  logic [1:0]         mres_q, mres_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               freeze_q, freeze_d;
  logic               finish;
  logic [1:0]         res;
  logic               running_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    round_d = round_q;
    p1w_d   = p1w_q;
    p2w_d   = p2w_q;
    rres_d  = rres_q;
    mres_d  = mres_q;
    finish  = 1'b0;
    res     = R_NONE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNTDOWN;
          timer_d = T_CD;
          round_d = 3'd1;
        end
      end
      S_COUNTDOWN: begin
        if (tick_q) begin
          if (timer_q == T_ONE) begin
            state_d = S_FIGHT;
            timer_d = T_FIGHT;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      S_FIGHT: begin
        // A knockout on the same cycle as the final tick wins over the timeout rule.
        if (p1_health == '0 || p2_health == '0) begin
          finish = 1'b1;
          if (p1_health == '0 && p2_health == '0) res = R_DRAW;
          else if (p1_health == '0)               res = R_P2;
          else                                    res = R_P1;
        end
`ifdef MATCH_TIMEOUT_EN
        else if (tick_q) begin
          if (timer_q == T_ONE) begin
            finish = 1'b1;
            if (p1_health > p2_health)      res = R_P1;
            else if (p2_health > p1_health) res = R_P2;
            else                            res = R_DRAW;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
`endif
        if (finish) begin
          state_d = S_ROUND_END;
          rres_d  = res;
          timer_d = T_HOLD;
          if (res == R_P1 && p1w_q < WIN_MAX) p1w_d = p1w_q + 3'd1;
          if (res == R_P2 && p2w_q < WIN_MAX) p2w_d = p2w_q + 3'd1;
        end
      end
      S_ROUND_END: begin
        if (tick_q) begin
          if (timer_q == T_ONE) begin
            if (p1w_q == WIN_MAX || p2w_q == WIN_MAX || round_q == ROUND_MAX) begin
              state_d = S_MATCH_END;
              timer_d = '0;
              if (p1w_q > p2w_q)      mres_d = R_P1;
              else if (p2w_q > p1w_q) mres_d = R_P2;
              else                    mres_d = R_DRAW;
            end else begin
              state_d = S_COUNTDOWN;
              timer_d = T_CD;
              rres_d  = R_NONE;
              if (round_q < ROUND_MAX) round_d = round_q + 3'd1;
            end
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      S_MATCH_END: begin
        if (start) begin
          state_d = S_IDLE;
          timer_d = '0;
          round_d = '0;
          p1w_d   = '0;
          p2w_d   = '0;
          rres_d  = R_NONE;
          mres_d  = R_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler restarts on every state change so each phase begins on a whole second.
  always_comb begin
    running_d = (state_d == S_COUNTDOWN) || (state_d == S_FIGHT) || (state_d == S_ROUND_END);
    if (state_d != state_q || !running_d) presc_d = '0;
    else if (presc_q == PRESC_MAX)        presc_d = '0;
    else                                  presc_d = presc_q + PW'(1);
    tick_d   = running_d && (presc_d == PRESC_MAX);
    freeze_d = (state_d != S_FIGHT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      round_q  <= '0;
      p1w_q    <= '0;
      p2w_q    <= '0;
      rres_q   <= R_NONE;
      mres_q   <= R_NONE;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      freeze_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      round_q  <= round_d;
      p1w_q    <= p1w_d;
      p2w_q    <= p2w_d;
      rres_q   <= rres_d;
      mres_q   <= mres_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      freeze_q <= freeze_d;
    end
  end

  assign match_state  = state_q;
  assign round_timer  = timer_q;
  assign round_num    = round_q;
  assign p1_wins      = p1w_q;
  assign p2_wins      = p2w_q;
  assign round_result = rres_q;
  assign match_result = mres_q;
  assign freeze       = freeze_q;
  assign tick         = tick_q;

endmodule
